// File: rtl/gpu_pkg.sv
// Shared types and screen constants for the pixel write path.
package gpu_pkg;

  localparam int WIDTH_BITS          = 10;
  localparam int HEIGHT_BITS         = 9;
  localparam int CHANNEL_BITS        = 8;
  localparam int DEF_SCREEN_WIDTH    = 640;
  localparam int DEF_SCREEN_HEIGHT   = 480;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } writer_state_t;

  // Linear address at full 32-bit product width; callers truncate.
  function automatic logic [31:0] pixel_addr(input pixel_t p, input int width);
    return 32'(p.y) * 32'(width) + 32'(p.x);
  endfunction

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous pixel FIFO with count-derived full/empty flags.
// A push while full is accepted only when a pop shares the same cycle.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  pixel_t wdata,
  output pixel_t rdata,
  output logic   full,
  output logic   empty,
  output logic   empty_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign rdata      = mem[rptr];
  assign empty_next = (count_next == '0);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Buffers rasteriser pixels and issues one req/ack framebuffer write per pixel.
// Optional PIXEL_CLIP_EN discards off-screen pixels at push and counts them.
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = 8,
  parameter int ADDR_BITS     = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic [WIDTH_BITS-1:0]     X,
  input  logic [HEIGHT_BITS-1:0]    Y,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  input  logic                      src_done,
  output logic                      mem_req,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [3*CHANNEL_BITS-1:0] mem_data,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef PIXEL_CLIP_EN
  ,
  output logic [15:0]               clip_count
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_param_check
    $error("gpu_pixel_writer: illegal parameter set");
  end

  writer_state_t state;
  writer_state_t state_next;
  logic          done_pending;
  logic          pending_next;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          fire;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_empty_next;
  pixel_t        in_pix;
  pixel_t        head;

`ifdef PIXEL_CLIP_EN
  assign in_range = (32'(X) < 32'(SCREEN_WIDTH)) && (32'(Y) < 32'(SCREEN_HEIGHT));
`else
  assign in_range = 1'b1;
`endif

  assign in_pix = '{x: X, y: Y, r: r_i, g: g_i, b: b_i};

  // IDLE pops unconditionally; WRITE only advances on the ack of the held entry.
  assign pop  = !fifo_empty && (state == IDLE || mem_ack);
  assign push = pix_valid && in_range && (!fifo_full || pop);
  assign fire = done_pending && state == IDLE && fifo_empty && !push;

  assign state_next   = pop ? WRITE : ((state == WRITE && mem_ack) ? IDLE : state);
  assign pending_next = fire ? 1'b0 : (src_done ? 1'b1 : done_pending);

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      (in_pix),
    .rdata      (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done_pending <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      done_pending <= pending_next;
      mem_req      <= (state_next == WRITE);
      done         <= fire;
      // Next-state view so busy is already low in the cycle done is high.
      busy         <= (state_next == WRITE) || !fifo_empty_next || pending_next;
      if (pop) begin
        mem_addr <= ADDR_BITS'(pixel_addr(head, SCREEN_WIDTH));
        mem_data <= {head.r, head.g, head.b};
      end
      if (pix_valid && in_range && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PIXEL_CLIP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= '0;
    end else if (pix_valid && !in_range && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Randomised self-checking bench for gpu_pixel_writer against a queue-based pixel model.
module tb_gpu_pixel_writer;
  import gpu_pkg::*;

  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int DEPTH = 8;
  localparam int AB    = 19;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      pix_valid;
  logic [WIDTH_BITS-1:0]     X;
  logic [HEIGHT_BITS-1:0]    Y;
  logic [CHANNEL_BITS-1:0]   r_i, g_i, b_i;
  logic                      src_done;
  logic                      mem_req;
  logic [AB-1:0]             mem_addr;
  logic [3*CHANNEL_BITS-1:0] mem_data;
  logic                      mem_ack;
  logic                      busy, done, overflow;
`ifdef PIXEL_CLIP_EN
  logic [15:0]               clip_count;
`endif

  gpu_pixel_writer #(
    .SCREEN_WIDTH (SW), .SCREEN_HEIGHT (SH), .FIFO_DEPTH (DEPTH), .ADDR_BITS (AB)
  ) dut (
    .clk (clk), .rst (rst), .pix_valid (pix_valid), .X (X), .Y (Y),
    .r_i (r_i), .g_i (g_i), .b_i (b_i), .src_done (src_done),
    .mem_req (mem_req), .mem_addr (mem_addr), .mem_data (mem_data),
    .mem_ack (mem_ack), .busy (busy), .done (done), .overflow (overflow)
`ifdef PIXEL_CLIP_EN
    , .clip_count (clip_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_mode = 0;   // 0: ack low, 1: ack high, 2: random ack

  logic [AB-1:0]             got_addr[$];
  logic [3*CHANNEL_BITS-1:0] got_data[$];
  logic [AB-1:0]             exp_addr[$];
  logic [3*CHANNEL_BITS-1:0] exp_data[$];
  int   done_cnt, done_cyc, last_wr_cyc;
  logic busy_at_done;

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && mem_req && mem_ack) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_data);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  task automatic drive(input logic pv, input int xx, input int yy,
                       input int rr, input int gg, input int bb, input logic sd);
    @(posedge clk);
    #1;
    pix_valid = pv;
    X         = WIDTH_BITS'(xx);
    Y         = HEIGHT_BITS'(yy);
    r_i       = CHANNEL_BITS'(rr);
    g_i       = CHANNEL_BITS'(gg);
    b_i       = CHANNEL_BITS'(bb);
    src_done  = sd;
    mem_ack   = (ack_mode == 0) ? 1'b0 : (ack_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_pix(input int xx, input int yy, input int rr, input int gg, input int bb);
    exp_addr.push_back(AB'((yy * SW + xx) % (1 << AB)));
    exp_data.push_back({CHANNEL_BITS'(rr), CHANNEL_BITS'(gg), CHANNEL_BITS'(bb)});
  endtask

  task automatic clear_log();
    got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
    done_cnt = 0; done_cyc = 0; last_wr_cyc = 0; busy_at_done = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1; rst = 1'b1;
    idle(2);
    @(posedge clk); #1; rst = 1'b0;
    clear_log();
  endtask

  task automatic compare_stream(input string tag);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, expected %0d", tag, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL %s_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 tag, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    pix_valid = 0; X = '0; Y = '0; r_i = '0; g_i = '0; b_i = '0; src_done = 0; mem_ack = 0;
    rst = 1'b1;
    idle(3);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, done, overflow} !== 4'b0000 || mem_addr !== '0 || mem_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b ovf=%b addr=%0d data=%h, expected all 0",
               mem_req, busy, done, overflow, mem_addr, mem_data);
    end
    clear_log();
  endtask

  task automatic test_single();
    ack_mode = 1;
    drive(1, 320, 240, 255, 255, 255, 0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL single_req_c1: got %b, expected 0", mem_req);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL single_req_c2: got %b, expected 0", mem_req);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== AB'(153920) || mem_data !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL single_req_c3: got req=%b addr=%0d data=%h, expected req=1 addr=153920 data=ffffff",
               mem_req, mem_addr, mem_data);
    end
    idle(5);
    checks++;
    if (got_addr.size() != 1) begin
      failures++; $display("FAIL single_writes: got %0d, expected 1", got_addr.size());
    end
  endtask

  task automatic test_stream();
    int rr, gg, bb;
    reset_dut();
    ack_mode = 1;
    for (int i = 0; i < 20; i++) begin
      rr = $urandom_range(0, 255); gg = $urandom_range(0, 255); bb = $urandom_range(0, 255);
      expect_pix(i, 0, rr, gg, bb);
      drive(1, i, 0, rr, gg, bb, (i == 19));
    end
    idle(10);
    compare_stream("stream");
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL stream_overflow: got %b, expected 0", overflow);
    end
    checks++;
    if (done_cnt != 1 || done_cyc <= last_wr_cyc) begin
      failures++;
      $display("FAIL stream_done: got %0d pulses at cycle %0d (last write %0d), expected 1 after last write",
               done_cnt, done_cyc, last_wr_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stream_busy: got at_done=%b end=%b, expected 0/0", busy_at_done, busy);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    ack_mode = 0;
    for (int i = 0; i < 20; i++) begin
      if (i <= DEPTH) expect_pix(i, 0, i, 2 * i, 3 * i);
      drive(1, i, 0, i, 2 * i, 3 * i, 0);
    end
    idle(10);
    checks++;
    if (overflow !== 1'b1 || got_addr.size() != 0) begin
      failures++;
      $display("FAIL overflow_flag: got ovf=%b writes=%0d, expected ovf=1 writes=0", overflow, got_addr.size());
    end
    ack_mode = 1;
    idle(20);
    checks++;
    if (got_addr.size() < DEPTH || got_addr.size() > DEPTH + 1) begin
      failures++; $display("FAIL overflow_writes: got %0d, expected 8 or 9", got_addr.size());
    end
    while (exp_addr.size() > got_addr.size()) begin
      void'(exp_addr.pop_back());
      void'(exp_data.pop_back());
    end
    compare_stream("overflow");
    checks++;
    if (overflow !== 1'b1 || done_cnt != 0) begin
      failures++; $display("FAIL overflow_sticky: got ovf=%b done=%0d, expected 1/0", overflow, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n_before;
    ack_mode = 0;
    for (int i = 0; i < 5; i++) drive(1, i, 7, 1, 2, 3, 0);
    idle(3);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || overflow !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: got req=%b ovf=%b, expected 1/1", mem_req, overflow);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_post: got req=%b busy=%b ovf=%b, expected 0/0/0", mem_req, busy, overflow);
    end
    n_before = got_addr.size();
    ack_mode = 1;
    idle(10);
    checks++;
    if (got_addr.size() != n_before || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: got %0d new writes req=%b, expected 0 and req=0",
               got_addr.size() - n_before, mem_req);
    end
  endtask

  task automatic test_clip();
    reset_dut();
    ack_mode = 1;
    drive(1, 639, 479, 10, 20, 30, 0);
    drive(1, 640, 0, 40, 50, 60, 0);
    drive(1, 0, 480, 70, 80, 90, 0);
    idle(10);
    expect_pix(639, 479, 10, 20, 30);
`ifdef PIXEL_CLIP_EN
    checks++;
    if (clip_count !== 16'd2) begin
      failures++; $display("FAIL clip_count: got %0d, expected 2", clip_count);
    end
`else
    expect_pix(640, 0, 40, 50, 60);
    expect_pix(0, 480, 70, 80, 90);
`endif
    compare_stream("clip");
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL clip_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_random_circle();
    int px[$], py[$];
    int idx, rr, gg, bb, budget;
    localparam int RAD = 12;
    reset_dut();
    ack_mode = 2;
    for (int dy = -RAD; dy <= RAD; dy++)
      for (int dx = -RAD; dx <= RAD; dx++)
        if (dx * dx + dy * dy <= RAD * RAD) begin
          px.push_back(320 + dx);
          py.push_back(240 + dy);
        end
    idx = 0;
    while (idx < px.size()) begin
      // Occupancy bound keeps the writer from ever dropping a pixel.
      if ((idx - got_addr.size()) < DEPTH && $urandom_range(0, 3) != 0) begin
        rr = $urandom_range(0, 255); gg = $urandom_range(0, 255); bb = $urandom_range(0, 255);
        expect_pix(px[idx], py[idx], rr, gg, bb);
        drive(1, px[idx], py[idx], rr, gg, bb, 0);
        idx++;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      budget++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++; $display("FAIL circle_timeout: got no done in 3000 cycles, expected one");
    end
    idle(5);
    compare_stream("circle");
    checks++;
    if (done_cnt != 1 || done_cyc <= last_wr_cyc || overflow !== 1'b0) begin
      failures++;
      $display("FAIL circle_done: got %0d pulses at %0d (last write %0d) ovf=%b, expected 1 after last write ovf=0",
               done_cnt, done_cyc, last_wr_cyc, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_reset_mid();
    test_clip();
    test_random_circle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
